// File: rtl/ram_pdp80x16_pkg.sv
// rtl/ram_pdp80x16_pkg.sv - shared geometry, power-state encoding and address check for the 80x16 PDP RAM controller
package ram_pdp80x16_pkg;

  localparam int RAM_DEPTH = 80;
  localparam int RAM_AW    = 7;
  localparam int RAM_DW    = 16;
  localparam int SLEEP_W   = 8;

  typedef enum logic [2:0] {
    ST_ACTIVE    = 3'd0,
    ST_SLP_ENTER = 3'd1,
    ST_SLEEP     = 3'd2,
    ST_SLP_EXIT  = 3'd3,
    ST_WAKE      = 3'd4
  } pwr_state_t;

  function automatic logic addr_ok(input logic [RAM_AW-1:0] a);
    return a < RAM_AW'(RAM_DEPTH);
  endfunction

endpackage

// File: rtl/ram_pdp80x16_slp_seq.sv
// rtl/ram_pdp80x16_slp_seq.sv - thermometer SLEEP_EN ramp: shifts a 1 in from bit 0 going up, drops the top bit going down
module ram_pdp80x16_slp_seq
  import ram_pdp80x16_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_up,
  input  logic               i_down,
  output logic [SLEEP_W-1:0] o_level,
  output logic               o_up_done,
  output logic               o_down_done,
  output logic               o_empty
);

  logic [SLEEP_W-1:0] r_level;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_level <= '0;
    else if (i_up)   r_level <= {r_level[SLEEP_W-2:0], 1'b1};
    else if (i_down) r_level <= {1'b0, r_level[SLEEP_W-1:1]};
  end

  // The level is always a contiguous run of ones from bit 0, so single bits tell the fill.
  assign o_level     = r_level;
  assign o_up_done   = r_level[SLEEP_W-2];
  assign o_down_done = ~r_level[1];
  assign o_empty     = ~r_level[0];

endmodule

// File: rtl/ram_pdp80x16_ctrl.sv
// rtl/ram_pdp80x16_ctrl.sv - access and power-sequencing controller for RAMPDP_80X16_GL_M2_D2
// Optional same-cycle write-to-read bypass: define RAMPDP80X16_CTRL_BYPASS_EN.
module ram_pdp80x16_ctrl
  import ram_pdp80x16_pkg::*;
#(
  parameter int         IDLE_CYCLES = 16,
  parameter int         WAKE_CYCLES = 2,
  parameter logic [7:0] SVOP_VAL    = 8'h00
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wr_req,
  input  logic [RAM_AW-1:0]  wr_addr,
  input  logic [RAM_DW-1:0]  wr_data,
  output logic               wr_ack,
  input  logic               rd_req,
  input  logic [RAM_AW-1:0]  rd_addr,
  output logic               rd_ack,
  output logic               rd_dvld,
  output logic [RAM_DW-1:0]  rd_data,
  output logic               err_oob,
  input  logic               sleep_req,
  output logic [2:0]         pwr_state,
  output logic               ram_we,
  output logic               ram_re,
  output logic [RAM_AW-1:0]  ram_wadr,
  output logic [RAM_AW-1:0]  ram_radr,
  output logic [RAM_DW-1:0]  ram_wd,
  input  logic [RAM_DW-1:0]  ram_rd,
  output logic [SLEEP_W-1:0] ram_sleep_en,
  output logic               ram_ret_en,
  output logic               ram_iddq,
  output logic [7:0]         ram_svop
);

  localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  pwr_state_t         r_state;
  pwr_state_t         w_next;
  logic [IW-1:0]      r_idle_cnt;
  logic [WW-1:0]      r_wake_cnt;
  logic               w_any_req;
  logic               w_active;
  logic               w_wr_ok;
  logic               w_rd_ok;
  logic               w_wr_fire;
  logic               w_rd_fire;
  logic               w_idle_hit;
  logic               w_up;
  logic               w_down;
  logic               w_up_done;
  logic               w_down_done;
  logic               w_empty;
  logic [SLEEP_W-1:0] w_level;
  logic               r_rd_p1;
  logic               r_dvld;
  logic               r_err;
  logic [RAM_DW-1:0]  r_rd_data;
  logic [RAM_DW-1:0]  w_ret_data;

  assign w_any_req  = wr_req | rd_req;
  assign w_active   = (r_state == ST_ACTIVE) & ~RST;
  assign w_wr_ok    = addr_ok(wr_addr);
  assign w_rd_ok    = addr_ok(rd_addr);
  assign wr_ack     = w_active & wr_req;
  assign rd_ack     = w_active & rd_req;
  assign w_wr_fire  = wr_ack & w_wr_ok;
  assign w_rd_fire  = rd_ack & w_rd_ok;
  assign w_idle_hit = (IDLE_CYCLES != 0) && (r_idle_cnt == IW'(IDLE_CYCLES));

  ram_pdp80x16_slp_seq u_slp_seq (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_up        (w_up),
    .i_down      (w_down),
    .o_level     (w_level),
    .o_up_done   (w_up_done),
    .o_down_done (w_down_done),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_next = r_state;
    w_up   = 1'b0;
    w_down = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        if (!w_any_req && (w_idle_hit || sleep_req)) w_next = ST_SLP_ENTER;
      end
      ST_SLP_ENTER: begin
        // An abort with nothing ramped yet skips straight to the settle phase.
        if (w_any_req) begin
          w_next = w_empty ? ST_WAKE : ST_SLP_EXIT;
        end else begin
          w_up = 1'b1;
          if (w_up_done) w_next = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (w_any_req) w_next = ST_SLP_EXIT;
      end
      ST_SLP_EXIT: begin
        w_down = 1'b1;
        if (w_down_done) w_next = ST_WAKE;
      end
      ST_WAKE: begin
        if (r_wake_cnt == WW'(WAKE_CYCLES - 1)) w_next = ST_ACTIVE;
      end
      default: w_next = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_ACTIVE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != ST_ACTIVE || w_any_req)     r_idle_cnt <= '0;
      else if (r_idle_cnt != IW'(IDLE_CYCLES))   r_idle_cnt <= r_idle_cnt + 1'b1;
      if (r_state == ST_WAKE) r_wake_cnt <= r_wake_cnt + 1'b1;
      else                    r_wake_cnt <= '0;
    end
  end

`ifdef RAMPDP80X16_CTRL_BYPASS_EN
  logic              r_byp_hit;
  logic [RAM_DW-1:0] r_byp_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_byp_hit  <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_byp_hit <= w_rd_fire & w_wr_fire & (rd_addr == wr_addr);
      if (w_wr_fire) r_byp_data <= wr_data;
    end
  end

  assign w_ret_data = r_byp_hit ? r_byp_data : ram_rd;
`else
  assign w_ret_data = ram_rd;
`endif

  // Macro drives ram_rd the cycle after RE; capture it then, present it one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_p1   <= 1'b0;
      r_dvld    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_p1 <= w_rd_fire;
      r_dvld  <= r_rd_p1;
      r_err   <= (wr_ack & ~w_wr_ok) | (rd_ack & ~w_rd_ok);
      if (r_rd_p1) r_rd_data <= w_ret_data;
    end
  end

  assign rd_dvld      = r_dvld;
  assign rd_data      = r_rd_data;
  assign err_oob      = r_err;
  assign pwr_state    = r_state;
  assign ram_we       = w_wr_fire;
  assign ram_re       = w_rd_fire;
  assign ram_wadr     = wr_addr;
  assign ram_radr     = rd_addr;
  assign ram_wd       = wr_data;
  assign ram_sleep_en = w_level;
  assign ram_ret_en   = (r_state == ST_SLEEP);
  assign ram_iddq     = 1'b0;
  assign ram_svop     = SVOP_VAL;

endmodule

// File: tb/tb_ram_pdp80x16_ctrl.sv
// tb/tb_ram_pdp80x16_ctrl.sv - directed bench with a per-cycle reference model for ram_pdp80x16_ctrl
module tb_ram_pdp80x16_ctrl;

  localparam int IDLE_CYCLES = 16;
  localparam int WAKE_CYCLES = 2;
  localparam logic [7:0] SVOP = 8'h5A;
`ifdef RAMPDP80X16_CTRL_BYPASS_EN
  localparam logic [15:0] BYP_EXP = 16'h1234;
`else
  localparam logic [15:0] BYP_EXP = 16'h0000;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wr_req = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic        rd_ack;
  logic        rd_dvld;
  logic [15:0] rd_data;
  logic        err_oob;
  logic        sleep_req = 1'b0;
  logic [2:0]  pwr_state;
  logic        ram_we, ram_re;
  logic [6:0]  ram_wadr, ram_radr;
  logic [15:0] ram_wd;
  logic [15:0] ram_rd = '0;
  logic [7:0]  ram_sleep_en;
  logic        ram_ret_en;
  logic        ram_iddq;
  logic [7:0]  ram_svop;

  int n_tests = 0;
  int n_fail  = 0;

  ram_pdp80x16_ctrl #(.IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .SVOP_VAL(SVOP)) dut (
    .CLK(CLK), .RST(RST),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_dvld(rd_dvld), .rd_data(rd_data), .err_oob(err_oob),
    .sleep_req(sleep_req), .pwr_state(pwr_state),
    .ram_we(ram_we), .ram_re(ram_re), .ram_wadr(ram_wadr), .ram_radr(ram_radr),
    .ram_wd(ram_wd), .ram_rd(ram_rd), .ram_sleep_en(ram_sleep_en),
    .ram_ret_en(ram_ret_en), .ram_iddq(ram_iddq), .ram_svop(ram_svop)
  );

  always #5 CLK = ~CLK;

  // Macro stand-in: read-before-write, data out the cycle after RE.
  logic [15:0] mac_mem [0:79];
  always @(posedge CLK) begin
    if (ram_re) ram_rd <= mac_mem[ram_radr];
    if (ram_we) mac_mem[ram_wadr] <= ram_wd;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: power level kept as a count of ramped bits, memory as a plain array.
  int          m_st = 0, m_lvl = 0, m_idle = 0, m_wake = 0;
  logic [15:0] m_mem [0:79];
  logic        m_p1 = 0, m_dv = 0, m_err = 0;
  logic [15:0] m_p1_data = '0, m_rd_data = '0;

  initial begin
    for (int i = 0; i < 80; i++) begin
      mac_mem[i] = '0;
      m_mem[i]   = '0;
    end
  end

  always @(posedge CLK) begin : model
    logic        req, act;
    logic [15:0] rv;
    if (RST) begin
      m_st = 0; m_lvl = 0; m_idle = 0; m_wake = 0;
      m_p1 = 0; m_dv = 0; m_err = 0; m_rd_data = '0;
    end else begin
      req = wr_req || rd_req;
      act = (m_st == 0);
      m_dv = m_p1;
      if (m_p1) m_rd_data = m_p1_data;
      m_p1 = act && rd_req && (rd_addr < 7'd80);
      if (m_p1) begin
        rv = m_mem[rd_addr];
`ifdef RAMPDP80X16_CTRL_BYPASS_EN
        if (wr_req && (wr_addr < 7'd80) && (wr_addr == rd_addr)) rv = wr_data;
`endif
        m_p1_data = rv;
      end
      m_err = act && ((wr_req && wr_addr >= 7'd80) || (rd_req && rd_addr >= 7'd80));
      if (act && wr_req && (wr_addr < 7'd80)) m_mem[wr_addr] = wr_data;
      case (m_st)
        0: begin
          if (req) m_idle = 0;
          else if (sleep_req || (IDLE_CYCLES != 0 && m_idle == IDLE_CYCLES)) begin
            m_st = 1; m_idle = 0;
          end else if (m_idle < IDLE_CYCLES) m_idle++;
        end
        1: begin
          if (req) begin m_st = (m_lvl == 0) ? 4 : 3; m_wake = 0; end
          else begin m_lvl++; if (m_lvl == 8) m_st = 2; end
        end
        2: if (req) m_st = 3;
        3: begin m_lvl--; if (m_lvl == 0) begin m_st = 4; m_wake = 0; end end
        default: begin m_wake++; if (m_wake == WAKE_CYCLES) begin m_st = 0; m_idle = 0; end end
      endcase
    end
  end

  always @(negedge CLK) begin : compare
    logic act, ewa, era;
    logic [7:0] esl;
    act = (m_st == 0) && !RST;
    ewa = act && wr_req;
    era = act && rd_req;
    esl = 8'((1 << m_lvl) - 1);
    cmp("pwr_state", 32'(pwr_state), 32'(m_st));
    cmp("sleep_en", 32'(ram_sleep_en), 32'(esl));
    cmp("ret_en", 32'(ram_ret_en), 32'(m_st == 2));
    cmp("wr_ack", 32'(wr_ack), 32'(ewa));
    cmp("rd_ack", 32'(rd_ack), 32'(era));
    cmp("ram_we", 32'(ram_we), 32'(ewa && wr_addr < 7'd80));
    cmp("ram_re", 32'(ram_re), 32'(era && rd_addr < 7'd80));
    cmp("rd_dvld", 32'(rd_dvld), 32'(m_dv));
    cmp("rd_data", 32'(rd_data), 32'(m_rd_data));
    cmp("err_oob", 32'(err_oob), 32'(m_err));
    cmp("ram_iddq", 32'(ram_iddq), 32'd0);
    cmp("ram_svop", 32'(ram_svop), 32'(SVOP));
    if (ram_we) cmp("ram_wadr", 32'(ram_wadr), 32'(wr_addr));
    if (ram_re) cmp("ram_radr", 32'(ram_radr), 32'(rd_addr));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] up_tab [8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
  logic [7:0] ab_tab [6] = '{8'h07, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00};

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n;
    tick(); tick();
    #1;
    cmp("rst_state", 32'(pwr_state), 32'd0);
    cmp("rst_sleep", 32'(ram_sleep_en), 32'd0);
    cmp("rst_ret", 32'(ram_ret_en), 32'd0);
    cmp("rst_dvld", 32'(rd_dvld), 32'd0);
    cmp("rst_data", 32'(rd_data), 32'd0);
    cmp("rst_err", 32'(err_oob), 32'd0);
    tick(); RST = 1'b0;

    tick(); wr_req = 1; wr_addr = 7'd5; wr_data = 16'hA5A5;
    #1; cmp("wr5_ack", 32'(wr_ack), 32'd1); cmp("wr5_we", 32'(ram_we), 32'd1);
    tick(); wr_req = 0; rd_req = 1; rd_addr = 7'd5;
    #1; cmp("rd5_ack", 32'(rd_ack), 32'd1); cmp("rd5_re", 32'(ram_re), 32'd1);
    tick(); rd_req = 0;
    #1; cmp("rd5_dvld_n1", 32'(rd_dvld), 32'd0);
    tick(); #1; cmp("rd5_dvld_n2", 32'(rd_dvld), 32'd1); cmp("rd5_data", 32'(rd_data), 32'hA5A5);
    tick(); #1; cmp("rd5_dvld_n3", 32'(rd_dvld), 32'd0);

    tick(); wr_req = 1; wr_addr = 7'd9; wr_data = 16'h1234; rd_req = 1; rd_addr = 7'd9;
    #1; cmp("same_wack", 32'(wr_ack), 32'd1); cmp("same_rack", 32'(rd_ack), 32'd1);
    tick(); wr_req = 0; rd_req = 0;
    tick(); #1; cmp("same_dvld", 32'(rd_dvld), 32'd1); cmp("same_data", 32'(rd_data), 32'(BYP_EXP));

    for (int i = 0; i <= 10; i++) begin
      tick(); wr_req = 1; wr_addr = 7'(i * 7); wr_data = 16'(16'h1000 + i * 16'h0111);
    end
    tick(); wr_addr = 7'd79; wr_data = 16'hBEEF;
    for (int i = 0; i <= 10; i++) begin
      tick(); wr_req = 0; rd_req = 1; rd_addr = 7'(i * 7);
    end
    tick(); rd_addr = 7'd79;
    tick(); rd_addr = 7'd80;
    tick(); rd_req = 0;
    #1; cmp("rd79_data", 32'(rd_data), 32'hBEEF); cmp("rd79_dvld", 32'(rd_dvld), 32'd1);
    cmp("rd80_err", 32'(err_oob), 32'd1);
    tick(); #1; cmp("rd80_nodvld", 32'(rd_dvld), 32'd0); cmp("rd80_err_off", 32'(err_oob), 32'd0);

    tick(); wr_req = 1; wr_addr = 7'd85; wr_data = 16'hDEAD;
    #1; cmp("oob_ack", 32'(wr_ack), 32'd1); cmp("oob_we", 32'(ram_we), 32'd0);
    tick(); wr_req = 0;
    #1; cmp("oob_err", 32'(err_oob), 32'd1);
    tick(); #1; cmp("oob_err_off", 32'(err_oob), 32'd0);

    tick(); wr_req = 1; wr_addr = 7'd3; wr_data = 16'hC3C3;
    tick(); wr_req = 0; n = 0;
    while (pwr_state == 3'd0 && n < 40) begin n++; tick(); end
    cmp("idle_len", 32'(n), 32'd17);
    for (int k = 0; k < 8; k++) begin
      cmp("ramp_up", 32'(ram_sleep_en), 32'(up_tab[k]));
      tick();
    end
    cmp("sleep_state", 32'(pwr_state), 32'd2);
    cmp("sleep_full", 32'(ram_sleep_en), 32'hFF);
    cmp("sleep_ret", 32'(ram_ret_en), 32'd1);

    sleep_req = 1; tick(); tick();
    cmp("sleep_hold", 32'(pwr_state), 32'd2);
    sleep_req = 0;
    tick(); rd_req = 1; rd_addr = 7'd3; n = 0;
    #1;
    while (!rd_ack && n < 30) begin tick(); #1; n++; end
    cmp("wake_lat", 32'(n), 32'd11);
    tick(); rd_req = 0;
    tick(); #1; cmp("wake_dvld", 32'(rd_dvld), 32'd1); cmp("wake_data", 32'(rd_data), 32'hC3C3);

    tick(); sleep_req = 1;
    tick(); sleep_req = 0; n = 0;
    while (!(pwr_state == 3'd1 && ram_sleep_en == 8'h07) && n < 30) begin tick(); n++; end
    cmp("abort_reach", 32'(n), 32'd3);
    rd_req = 1; rd_addr = 7'd5;
    #1;
    for (int k = 0; k < 6; k++) begin
      cmp("abort_seq", 32'(ram_sleep_en), 32'(ab_tab[k]));
      cmp("abort_noack", 32'(rd_ack), 32'd0);
      tick(); #1;
    end
    cmp("abort_ack", 32'(rd_ack), 32'd1);
    tick(); rd_req = 0;
    tick(); #1; cmp("abort_dvld", 32'(rd_dvld), 32'd1); cmp("abort_data", 32'(rd_data), 32'hA5A5);

    tick(); sleep_req = 1; n = 0;
    while (pwr_state != 3'd2 && n < 30) begin tick(); n++; end
    cmp("entry_len", 32'(n), 32'd9);
    sleep_req = 0; rd_req = 1; rd_addr = 7'd3;
    tick(); tick(); tick();
    cmp("in_exit", 32'(pwr_state), 32'd3);
    cmp("in_exit_lvl", 32'(ram_sleep_en), 32'h3F);
    RST = 1; rd_req = 0;
    tick(); #1;
    cmp("mrst_state", 32'(pwr_state), 32'd0);
    cmp("mrst_sleep", 32'(ram_sleep_en), 32'd0);
    cmp("mrst_ret", 32'(ram_ret_en), 32'd0);
    cmp("mrst_dvld", 32'(rd_dvld), 32'd0);
    cmp("mrst_data", 32'(rd_data), 32'd0);
    cmp("mrst_err", 32'(err_oob), 32'd0);
    RST = 0;

    tick(); rd_req = 1; rd_addr = 7'd3;
    tick(); rd_req = 0;
    tick(); #1; cmp("post_dvld", 32'(rd_dvld), 32'd1); cmp("post_data", 32'(rd_data), 32'hC3C3);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_pdp80x16_ctrl.md
# ram_pdp80x16_ctrl

Access and power-sequencing controller for one 80-word × 16-bit pseudo-dual-port RAM macro (`RAMPDP_80X16_GL_M2_D2`).
- Accepts independent write and read requests through req/ack handshakes and drives the macro's WE/WADR/WD and RE/RADR ports.
- Returns registered read data with a valid strobe.
- After a programmable idle period, walks the macro into sleep by ramping SLEEP_EN[7:0] one bit per cycle, and walks it back out on demand.
- Sits between a client datapath and the macro instance; the macro itself is unchanged.

## Interface
Parameters:
- IDLE_CYCLES, 16: consecutive idle cycles in ACTIVE before auto-sleep; 0 disables auto-sleep.
- WAKE_CYCLES, 2: settle cycles after SLEEP_EN reaches 0 before accepting requests (minimum 1).
- SVOP_VAL, 8'h00: constant driven on ram_svop.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock for the controller and the macro.
- RST  in  1  synchronous active-high reset.
- wr_req  in  1  write request; held until wr_ack.
- wr_addr  in  7  write address.
- wr_data  in  16  write data.
- wr_ack  out  1  write accepted this cycle.
- rd_req  in  1  read request; held until rd_ack.
- rd_addr  in  7  read address.
- rd_ack  out  1  read accepted this cycle.
- rd_dvld  out  1  rd_data valid.
- rd_data  out  16  read data.
- err_oob  out  1  one-cycle pulse: an accepted request had address ≥ 80.
- sleep_req  in  1  force sleep entry when idle (level).
- pwr_state  out  3  encoded FSM state.
- ram_we, ram_re  out  1  macro WE and RE.
- ram_wadr, ram_radr  out  7  macro addresses.
- ram_wd  out  16  macro write data.
- ram_rd  in  16  macro read data.
- ram_sleep_en  out  8  macro SLEEP_EN[7:0].
- ram_ret_en  out  1  macro RET_EN.
- ram_iddq  out  1  tied 0.
- ram_svop  out  8  equals SVOP_VAL.

## Operation
FSM states, in pwr_state encoding order: ACTIVE(0), SLP_ENTER(1), SLEEP(2), SLP_EXIT(3), WAKE(4).

ACTIVE
- wr_ack = wr_req; rd_ack = rd_req. Both are combinational, and a read and a write are accepted in the same cycle.
- An accepted request with addr < 80 drives the matching macro strobe combinationally in that cycle.
- An accepted request with addr ≥ 80 is acked, no macro strobe is issued, and err_oob pulses the next cycle.
- The idle counter clears on any request. Otherwise it increments, saturating at IDLE_CYCLES.
- Leave to SLP_ENTER when there is no request and either (IDLE_CYCLES ≠ 0 and counter == IDLE_CYCLES) or sleep_req = 1.

SLP_ENTER
- Each cycle sets the next SLEEP_EN bit, bit 0 first, bit 7 last.
- Goes to SLEEP on the cycle after bit 7 is set.
- A request arriving here aborts the entry: go to SLP_EXIT starting from the current level.

SLEEP
- ram_sleep_en = 8'hFF; ram_ret_en = 1.
- Any wr_req or rd_req goes to SLP_EXIT. sleep_req is ignored.

SLP_EXIT
- ram_ret_en = 0.
- Each cycle clears the highest set bit of ram_sleep_en. Goes to WAKE once it is 0.

WAKE
- Counts WAKE_CYCLES cycles, then goes to ACTIVE with the idle counter cleared.

Outside ACTIVE:
- wr_ack = rd_ack = 0, and ram_we = ram_re = 0.
- Held requests are served once ACTIVE resumes.

Reset values:
- State ACTIVE; ram_sleep_en = 0; ram_ret_en = 0.
- rd_dvld = 0; rd_data = 0; err_oob = 0; idle counter = 0.

Reset mid-sequence (any state) returns to ACTIVE with ram_sleep_en = 0 immediately. No ramp is performed on reset.

## Timing
- Write: macro sampled at the CLK edge ending the ack cycle.
- Read latency:
  - Cycle N: rd_ack = 1, ram_re = 1.
  - Cycle N+1: macro drives ram_rd; rd_data is registered at the end of N+1.
  - Cycle N+2: rd_dvld = 1 for one cycle.
- An out-of-range read produces no rd_dvld.
- Back-to-back reads give one rd_dvld per cycle.
- Sleep entry from the exit condition to SLEEP takes 9 cycles: 8 ramp cycles plus 1.
- Wake from request to ack: popcount(ram_sleep_en) + WAKE_CYCLES + 1 cycles; 8 + WAKE_CYCLES + 1 from full sleep.

## Configuration
Macro RAMPDP80X16_CTRL_BYPASS_EN:
- Defined: when an in-range read and an in-range write to the same address are accepted in the same cycle, the rd_data returned two cycles later is the newly written wr_data. This uses a one-entry bypass register with a hit flag.
- Undefined: same-address read returns the macro's pre-write contents. There is no bypass logic.

## Structure
- Shared package ram_pdp80x16_pkg holds:
  - the pwr_state enum;
  - RAM_DEPTH = 80, RAM_AW = 7, RAM_DW = 16, SLEEP_W = 8.
- One natural sub-module: ram_pdp80x16_slp_seq, the SLEEP_EN ramp shifter with load-up, load-down and done outputs.
- The top contains the FSM, the idle/wake counters and the read-return pipe.

## Test plan
- Write 16'hA5A5 to addr 5, then read addr 5 → rd_dvld 2 cycles after rd_ack with rd_data = 16'hA5A5.
- Same-cycle write 16'h1234 and read, both at addr 9, where addr 9 previously held 16'h0000:
  - with BYPASS_EN → rd_data = 16'h1234;
  - without → 16'h0000.
- Idle 16 cycles → ram_sleep_en steps 01, 03 … FF over 8 cycles, then ram_ret_en = 1.
- From SLEEP, assert rd_req at addr 3 → sleep_en steps down to 00 over 8 cycles, then WAKE for 2 cycles, then rd_ack; data unchanged.
- rd_req arrives while ram_sleep_en = 8'h07 in SLP_ENTER → sequence 03, 01, 00, then WAKE, then ack.
- Write to addr 85 → wr_ack = 1, ram_we = 0, err_oob pulses once. RST asserted mid-SLP_EXIT → all outputs at reset values the next cycle.
